// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader slice.
// Parity option macro: FIFO_RD_PARITY_EN (consumed by fifo_stream_reader).
package fifo_rd_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int OCC_W      = 2;

   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;
endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry in-order skid buffer; entry0_q is always the head word.
// state | meaning
// EMPTY | no word held, head not valid
// ONE   | entry0_q holds the head word
// TWO   | entry0_q head, entry1_q next word
module fifo_rd_skid2
   import fifo_rd_pkg::*;
#(
   parameter int W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [W-1:0]     push_data_i,
   input  logic             pop_i,
   output logic [W-1:0]     head_o,
   output logic [OCC_W-1:0] occ_o
);
   occ_t         occ_q;
   logic [W-1:0] entry0_q;
   logic [W-1:0] entry1_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         occ_q    <= EMPTY;
         entry0_q <= '0;
         entry1_q <= '0;
      end else begin
         case (occ_q)
            EMPTY: begin
               if (push_i) begin
                  entry0_q <= push_data_i;
                  occ_q    <= ONE;
               end
            end
            ONE: begin
               case ({push_i, pop_i})
                  2'b11: entry0_q <= push_data_i;
                  2'b10: begin
                     entry1_q <= push_data_i;
                     occ_q    <= TWO;
                  end
                  2'b01: occ_q <= EMPTY;
                  default: ;
               endcase
            end
            TWO: begin
               if (pop_i) begin
                  entry0_q <= entry1_q;
                  if (push_i) entry1_q <= push_data_i;
                  else        occ_q    <= ONE;
               end
            end
            default: occ_q <= EMPTY;
         endcase
      end
   end

   // The requester reserves a slot for every accepted read, so a push into a full, non-popping buffer is a bug.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(push_i && !pop_i && occ_q == TWO));
      end
   end

   assign head_o = entry0_q;
   assign occ_o  = occ_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// Drain-side adapter: FIFO read strobe + one-cycle read latency tracking into a valid/ready stream.
// Optional per-word even parity output when FIFO_RD_PARITY_EN is defined.
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   output logic              fifo_rn,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   input  logic              fifo_wn,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_PARITY_EN
   ,
   output logic              m_parity
`endif
);
`ifdef FIFO_RD_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int ENT_W = DATA_W + PAR_W;

   logic             pend_q;
   logic             acc;
   logic             pop;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] committed;
   logic [ENT_W-1:0] push_data;
   logic [ENT_W-1:0] head;

   assign m_valid = (occ != EMPTY);
   assign pop     = m_valid & m_ready;

   // A word already in flight (pend_q) holds a slot just like a buffered one.
   assign committed = occ + {1'b0, pend_q} - {1'b0, pop};
   assign fifo_rn   = !reset & !fifo_empty & (committed < 2'd2);

   // The FIFO drops our read when it takes a write in the same cycle.
   assign acc = fifo_rn & !fifo_empty & !(fifo_wn & !fifo_full);

   always_ff @(posedge clock) begin
      if (reset) pend_q <= 1'b0;
      else       pend_q <= acc;
   end

`ifdef FIFO_RD_PARITY_EN
   assign push_data = {^fifo_data, fifo_data};
   assign m_parity  = head[DATA_W];
`else
   assign push_data = fifo_data;
`endif

   fifo_rd_skid2 #(
      .W (ENT_W)
   ) u_skid (
      .clock       (clock),
      .reset       (reset),
      .push_i      (pend_q),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .occ_o       (occ)
   );

   assign m_data = head[DATA_W-1:0];
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 8-deep write-priority FIFO upstream.
module tb_fifo_stream_reader;
   logic       clock = 1'b0;
   logic       reset;
   logic       fifo_rn;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_wn;
   logic [7:0] fifo_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
`ifdef FIFO_RD_PARITY_EN
   logic       m_parity;
`endif

   logic [7:0] wdata;
   logic [7:0] mem [0:7];
   logic [2:0] wr_ptr = 3'd0;
   logic [2:0] rd_ptr = 3'd0;
   logic [3:0] cnt    = 4'd0;
   int         n_cmp  = 0;
   int         n_err  = 0;

   always #5 clock = ~clock;

   fifo_stream_reader dut (
      .clock      (clock),
      .reset      (reset),
      .fifo_rn    (fifo_rn),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_wn    (fifo_wn),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
`ifdef FIFO_RD_PARITY_EN
      ,
      .m_parity   (m_parity)
`endif
   );

   assign fifo_empty = (cnt == 4'd0);
   assign fifo_full  = (cnt == 4'd8);

   // Upstream FIFO: registered read data, write wins over read.
   always @(posedge clock) begin
      logic w, r;
      w = fifo_wn && !fifo_full;
      r = fifo_rn && !fifo_empty && !w;
      if (w) begin
         mem[wr_ptr] <= wdata;
         wr_ptr      <= wr_ptr + 3'd1;
      end
      if (r) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 3'd1;
      end
      cnt <= cnt + {3'd0, w} - {3'd0, r};
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b1;
      m_ready   = 1'b0;
      fifo_wn   = 1'b0;
      wdata     = 8'h00;
      fifo_data = 8'h00;

      // preload 0x11..0x88 while the reader is held in reset
      for (int i = 0; i < 8; i++) begin
         fifo_wn = 1'b1;
         wdata   = 8'(8'h11 * (i + 1));
         tick();
      end
      fifo_wn = 1'b0;
      for (int r = 0; r < 3; r++) begin
         tick();
         chk("rst_rn", fifo_rn, 0);
         chk("rst_valid", m_valid, 0);
         chk("rst_data", m_data, 0);
      end

      // streaming
      reset   = 1'b0;
      m_ready = 1'b1;
      #1;
      chk("first_rn", fifo_rn, 1);
      chk("first_valid", m_valid, 0);
      tick();
      chk("lat1_valid", m_valid, 0);
      chk("lat1_pend", dut.pend_q, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("stream_valid", m_valid, 1);
         chk("stream_data", m_data, 32'h11 * (i + 1));
      end
      tick();
      chk("drain_valid", m_valid, 0);
      chk("drain_rn", fifo_rn, 0);

      // back-pressure
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fifo_wn = 1'b1;
         wdata   = 8'(8'h11 * (i + 1));
         tick();
      end
      fifo_wn = 1'b0;
      repeat (5) tick();
      chk("bp_rn", fifo_rn, 0);
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 32'h11);
      chk("bp_occ", dut.u_skid.occ_q, 2);
      m_ready = 1'b1;
      #1;
      chk("bp_rel_rn", fifo_rn, 1);
      tick();
      chk("bp_data2", m_data, 32'h22);
      tick();
      chk("bp_data3", m_data, 32'h33);
      tick();
      chk("bp_data4", m_data, 32'h44);
      chk("bp_valid4", m_valid, 1);
      tick();
      chk("bp_end_valid", m_valid, 0);

      // write collision
      fifo_wn = 1'b1;
      wdata   = 8'hC1;
      tick();
      wdata = 8'hC2;
      #1;
      chk("col_rn", fifo_rn, 1);
      tick();
      fifo_wn = 1'b0;
      #1;
      chk("col_pend0", dut.pend_q, 0);
      chk("col_retry_rn", fifo_rn, 1);
      tick();
      chk("col_pend1", dut.pend_q, 1);
      tick();
      chk("col_valid1", m_valid, 1);
      chk("col_data1", m_data, 32'hC1);
      tick();
      chk("col_valid2", m_valid, 1);
      chk("col_data2", m_data, 32'hC2);
      tick();
      chk("col_end_valid", m_valid, 0);

      // empty boundary
      fifo_wn = 1'b1;
      wdata   = 8'hA5;
      tick();
      fifo_wn = 1'b0;
      tick();
      chk("emp_pre_valid", m_valid, 0);
      tick();
      chk("emp_valid", m_valid, 1);
      chk("emp_data", m_data, 32'hA5);
      chk("emp_rn", fifo_rn, 0);
      tick();
      chk("emp_post_valid", m_valid, 0);
      chk("emp_post_rn", fifo_rn, 0);

`ifdef FIFO_RD_PARITY_EN
      fifo_wn = 1'b1;
      wdata   = 8'h07;
      tick();
      wdata = 8'h03;
      tick();
      fifo_wn = 1'b0;
      for (int k = 0; k < 10 && !m_valid; k++) tick();
      chk("par_valid1", m_valid, 1);
      chk("par_data1", m_data, 32'h07);
      chk("par_bit1", m_parity, 1);
      tick();
      chk("par_valid2", m_valid, 1);
      chk("par_data2", m_data, 32'h03);
      chk("par_bit2", m_parity, 0);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
